// File: rtl/wisc_pkg.sv
// Shared halt-path constants and state type for the fetch-side halt controller.
package wisc_pkg;

    localparam logic [3:0]  OPCODE_HLT      = 4'hF;
    localparam logic [15:0] NOP_INSTR       = 16'h0000;
    localparam int unsigned DRAIN_MAX       = 8;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned HALT_PIPE_DEPTH = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hlt_state_t;

endpackage

// File: rtl/hlt_drain_timer.sv
// Saturating drain-cycle counter; flags the cycle that is the MAX-th cycle spent draining.
module hlt_drain_timer
    import wisc_pkg::*;
#(
    parameter int unsigned MAX = DRAIN_MAX,
    parameter int unsigned W   = CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire_c
);

    logic [W-1:0] cnt;

    // Counter is zeroed on the edge that enters DRAIN and saturates at MAX.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1);
        end
    end

    // cnt counts completed drain cycles, so cnt == MAX-1 marks the MAX-th one.
    assign expire_c = run && (cnt >= W'(MAX - 1));

endmodule

// File: rtl/hlt_fetch_ctrl.sv
// Fetch-side halt control: accepts HLT in ID, freezes PC, injects NOPs while the
// halt drains, and reports the retired halt. Optional drain watchdog is built
// when HLT_WATCHDOG_EN is defined.
module hlt_fetch_ctrl
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id_instr,
    input  logic        id_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        hlt_wb,
    output logic        hlt_found,
    output logic        pc_freeze,
    output logic        nop_inject,
    output logic [15:0] nop_instr,
    output logic        halted,
    output logic        drain_err
);

    hlt_state_t state;
    logic       is_hlt;
    logic       expire_c;

    // HLT acceptance is zero-latency; a stalled HLT retries, a flushed one is wrong-path.
    assign is_hlt    = id_valid && (id_instr[15:12] == OPCODE_HLT);
    assign hlt_found = !rst && (state == RUN) && is_hlt && !stall && !flush;
    assign pc_freeze = hlt_found || nop_inject;
    assign nop_instr = NOP_INSTR;

`ifdef HLT_WATCHDOG_EN
    hlt_drain_timer #(
        .MAX (DRAIN_MAX),
        .W   (CNT_W)
    ) u_drain_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (hlt_found),
        .run      (state == DRAIN),
        .expire_c (expire_c)
    );
`else
    assign expire_c = 1'b0;
`endif

    // Halt FSM with registered drain/halt outputs; hlt_wb outside DRAIN is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            nop_inject <= 1'b0;
            halted     <= 1'b0;
            drain_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (hlt_found) begin
                        state      <= DRAIN;
                        nop_inject <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (hlt_wb) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (expire_c) begin
                        state     <= HALTED;
                        halted    <= 1'b1;
                        drain_err <= 1'b1;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state      <= RUN;
                    nop_inject <= 1'b0;
                    halted     <= 1'b0;
                    drain_err  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hlt_fetch_ctrl.sv
// Directed bench for hlt_fetch_ctrl; watchdog expectations follow HLT_WATCHDOG_EN.
module tb_hlt_fetch_ctrl;
    import wisc_pkg::*;

    localparam logic [15:0] EXP_NOP = 16'h0000;
    localparam logic [15:0] HLT_OP  = 16'hF000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] id_instr;
    logic        id_valid;
    logic        stall;
    logic        flush;
    logic        hlt_wb;
    logic        hlt_found;
    logic        pc_freeze;
    logic        nop_inject;
    logic [15:0] nop_instr;
    logic        halted;
    logic        drain_err;

    int errors = 0;
    int checks = 0;

    // Observed vector: {hlt_found, pc_freeze, nop_inject, halted, drain_err}
    logic [4:0] outs;
    assign outs = {hlt_found, pc_freeze, nop_inject, halted, drain_err};

    hlt_fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .id_instr   (id_instr),
        .id_valid   (id_valid),
        .stall      (stall),
        .flush      (flush),
        .hlt_wb     (hlt_wb),
        .hlt_found  (hlt_found),
        .pc_freeze  (pc_freeze),
        .nop_inject (nop_inject),
        .nop_instr  (nop_instr),
        .halted     (halted),
        .drain_err  (drain_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_instr = 16'h0000;
        id_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        hlt_wb   = 1'b0;
    endtask

    task automatic drive_hlt();
        id_instr = HLT_OP;
        id_valid = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outs: got %b expected %b", outs, 5'b00000);
        end
        checks++;
        if (nop_instr !== EXP_NOP) begin
            errors++;
            $display("FAIL reset_nop_instr: got %h expected %h", nop_instr, EXP_NOP);
        end
    endtask

    task automatic test_normal_halt();
        do_reset();
        step();
        // cycle T: HLT accepted combinationally
        drive_hlt();
        #1;
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL normal_accept: got %b expected %b", outs, 5'b11000);
        end
        step();
        // T+1: draining, HLT gone from ID
        idle();
        #1;
        checks++;
        if (outs !== 5'b01100) begin
            errors++;
            $display("FAIL normal_drain1: got %b expected %b", outs, 5'b01100);
        end
        step();
        // T+2: HLT-looking word with stall/flush must not be re-accepted
        drive_hlt();
        stall = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b01100) begin
            errors++;
            $display("FAIL normal_drain_ignore: got %b expected %b", outs, 5'b01100);
        end
        step();
        // T+3: halt reaches WB
        idle();
        hlt_wb = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b01100) begin
            errors++;
            $display("FAIL normal_wb_cycle: got %b expected %b", outs, 5'b01100);
        end
        step();
        // T+4: halted
        idle();
        #1;
        checks++;
        if (outs !== 5'b01110) begin
            errors++;
            $display("FAIL normal_halted: got %b expected %b", outs, 5'b01110);
        end
    endtask

    task automatic test_stalled_halt();
        do_reset();
        drive_hlt();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (outs !== 5'b00000) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %b expected %b", i, outs, 5'b00000);
            end
            step();
        end
        stall = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL stall_release: got %b expected %b", outs, 5'b11000);
        end
        step();
        idle();
        #1;
        checks++;
        if (outs !== 5'b01100) begin
            errors++;
            $display("FAIL stall_drain: got %b expected %b", outs, 5'b01100);
        end
    endtask

    task automatic test_flushed_halt();
        do_reset();
        drive_hlt();
        flush = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL flush_reject: got %b expected %b", outs, 5'b00000);
        end
        step();
        idle();
        id_instr = 16'h1234;
        id_valid = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL flush_still_run: got %b expected %b", outs, 5'b00000);
        end
        step();
        // stray hlt_wb in RUN must be ignored
        idle();
        hlt_wb = 1'b1;
        step();
        idle();
        #1;
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL run_stray_wb: got %b expected %b", outs, 5'b00000);
        end
        step();
        drive_hlt();
        #1;
        checks++;
        if (outs !== 5'b11000) begin
            errors++;
            $display("FAIL flush_later_accept: got %b expected %b", outs, 5'b11000);
        end
        step();
        idle();
        #1;
        checks++;
        if (outs !== 5'b01100) begin
            errors++;
            $display("FAIL flush_later_drain: got %b expected %b", outs, 5'b01100);
        end
    endtask

    task automatic test_watchdog();
        logic [1:0] exp_hd;
        do_reset();
        drive_hlt();
        step();
        idle();
        for (int i = 1; i <= 40; i++) begin
            #1;
`ifdef HLT_WATCHDOG_EN
            exp_hd = (i >= DRAIN_MAX + 1) ? 2'b11 : 2'b00;
`else
            exp_hd = 2'b00;
`endif
            checks++;
            if ({halted, drain_err} !== exp_hd) begin
                errors++;
                $display("FAIL watchdog_T+%0d: got halted/drain_err %b expected %b",
                         i, {halted, drain_err}, exp_hd);
            end
            step();
        end
    endtask

    task automatic test_wb_at_limit();
        do_reset();
        drive_hlt();
        step();
        idle();
        for (int i = 1; i < DRAIN_MAX; i++) step();
        // T+DRAIN_MAX: last cycle before expiry, halt arrives just in time
        hlt_wb = 1'b1;
        step();
        idle();
        #1;
        checks++;
        if (outs !== 5'b01110) begin
            errors++;
            $display("FAIL wb_at_limit: got %b expected %b", outs, 5'b01110);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        drive_hlt();
        step();
        idle();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL mid_drain_reset: got %b expected %b", outs, 5'b00000);
        end
        step();
        step();
        drive_hlt();
        step();
        idle();
        step();
        step();
        hlt_wb = 1'b1;
        step();
        idle();
        #1;
        checks++;
        if (outs !== 5'b01110) begin
            errors++;
            $display("FAIL mid_drain_rehalt: got %b expected %b", outs, 5'b01110);
        end
    endtask

    task automatic test_sticky_halt();
        // continues from the HALTED state left by the previous task
        for (int i = 0; i < 6; i++) begin
            drive_hlt();
            hlt_wb = i[0];
            #1;
            checks++;
            if (outs !== 5'b01110) begin
                errors++;
                $display("FAIL sticky_%0d: got %b expected %b", i, outs, 5'b01110);
            end
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b00000) begin
            errors++;
            $display("FAIL sticky_reset_clear: got %b expected %b", outs, 5'b00000);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_normal_halt();
        test_stalled_halt();
        test_flushed_halt();
        test_watchdog();
        test_wb_at_limit();
        test_reset_mid_drain();
        test_sticky_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hlt_fetch_ctrl.md
Name: hlt_fetch_ctrl

Overview:
- Front-end counterpart of the halt pipe: detects the HLT opcode in the ID-stage instruction and emits the one-cycle `hlt_found` into the ID/EX halt flop.
- Freezes the PC and injects NOPs into IF/ID while the pipeline drains.
- Watches the writeback-stage halt (`hlt_wb`) and raises a sticky `halted` for the testbench/top level.
- Sits between the fetch unit, the hazard unit, and the halt pipeline registers.

Parameters:
- OPCODE_HLT, 4'hF, opcode value in instr[15:12] that identifies HLT.
- NOP_INSTR, 16'h0000, encoding loaded into IF/ID while draining.
- DRAIN_MAX, 8, cycles allowed between hlt_found and hlt_wb before a drain error (watchdog builds only).
- CNT_W, 4, drain counter width; must satisfy 2^CNT_W > DRAIN_MAX.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_instr  in  16  instruction currently in the IF/ID register.
- id_valid  in  1  id_instr is a real instruction, not a bubble.
- stall  in  1  hazard unit holds IF/ID this cycle.
- flush  in  1  taken branch resolved in EX this cycle; squashes IF/ID.
- hlt_wb  in  1  halt has reached MEM/WB (output of the halt pipe).
- hlt_found  out  1  to ID/EX halt flop; HLT accepted this cycle.
- pc_freeze  out  1  hold PC, no PC increment.
- nop_inject  out  1  force NOP_INSTR into IF/ID next edge.
- nop_instr  out  16  constant NOP_INSTR.
- halted  out  1  sticky: the halt has retired.
- drain_err  out  1  sticky: the drain watchdog expired.

Behaviour:
- States: RUN, DRAIN, HALTED (2-bit encoded). Reset → RUN, counter = 0. Reset values of all outputs are 0, except nop_instr, which is the constant NOP_INSTR.
- is_hlt = id_valid && (id_instr[15:12] == OPCODE_HLT).
- RUN:
  - hlt_found = is_hlt && !stall && !flush. This is combinational, zero latency.
  - pc_freeze = hlt_found (combinational), so the instruction fetched in the same cycle is not followed by a PC advance.
  - When hlt_found = 1 → DRAIN next edge; counter cleared.
- Stall with is_hlt: hlt_found = 0 and state stays RUN. The HLT is re-evaluated on every following cycle until stall drops.
- Flush with is_hlt (same cycle): the HLT lies on the wrong path. hlt_found = 0, state stays RUN, no freeze.
- DRAIN:
  - pc_freeze = 1 and nop_inject = 1 every cycle; hlt_found = 0.
  - flush and stall are ignored for state purposes: an older branch cannot resolve after the HLT has left ID.
  - Counter increments each cycle, saturating at DRAIN_MAX.
  - hlt_wb = 1 → HALTED next edge; halted = 1 from that edge.
  - Nominal: hlt_found at cycle T gives hlt_wb at T+3, halted at T+4.
- HALTED:
  - pc_freeze = 1, nop_inject = 1, halted = 1, held until rst.
  - A further is_hlt or hlt_wb has no effect.
- hlt_wb while in RUN: protocol violation. It is ignored and does not set halted.
- rst mid-DRAIN or in HALTED: the next edge returns to RUN and clears halted, drain_err and the counter. The halt pipe is reset by the same rst.

Optional Feature:
- Macro: HLT_WATCHDOG_EN.
- Defined:
  - In DRAIN, if the counter reaches DRAIN_MAX with hlt_wb still 0, then on the next edge drain_err = 1 (sticky) and state → HALTED, so halted = 1 as well.
  - If hlt_wb is asserted in the same cycle the counter reaches DRAIN_MAX, the halt completes normally and drain_err stays 0.
- Undefined:
  - No counter logic; drain_err tied to 0.
  - DRAIN waits indefinitely for hlt_wb.

Decomposition:
- Shared package wisc_pkg holds:
  - OPCODE_HLT and NOP_INSTR constants.
  - The state typedef hlt_state_t {RUN, DRAIN, HALTED}.
  - HALT_PIPE_DEPTH = 3, the ID→WB latency used by benches.
- One natural sub-module: hlt_drain_timer, the saturating counter plus expiry compare. It is instantiated only under HLT_WATCHDOG_EN.

Test Plan:
1. Normal halt: reset, then id_instr=16'hF000, id_valid=1 at cycle 5 → hlt_found=1 and pc_freeze=1 at cycle 5. Drive hlt_wb=1 at cycle 8 → halted=1 from cycle 9; nop_inject=1 on cycles 6–∞; drain_err=0.
2. Stalled halt: HLT present cycles 5–7 with stall=1 on 5–6 → hlt_found=0 on 5–6 and 1 at cycle 7 only; DRAIN entered at cycle 8.
3. Flushed halt: HLT with flush=1 at cycle 5, then id_instr=16'h1234 → hlt_found=0, pc_freeze=0, state RUN. A later real HLT at cycle 10 is accepted.
4. Watchdog (HLT_WATCHDOG_EN, DRAIN_MAX=8): hlt_found at cycle 5 and hlt_wb never asserted → drain_err=1 and halted=1 at cycle 14. Without the macro, both stay 0 through cycle 40.
5. Reset mid-drain: hlt_found at cycle 5, rst=1 at cycle 7 → all outputs 0 at cycle 8. A fresh HLT at cycle 10 halts normally.
6. Sticky halt: in HALTED, drive further HLTs and hlt_wb pulses → hlt_found stays 0, halted stays 1.
